// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: hazard controls, EX redirects, instruction memory,
// IF/ID outputs and BTB update port. The master side drives the fetch stage.
interface fetch_stage_if #(
   parameter int XLEN = 64
);
   logic            stall_f;
   logic            stall_d;
   logic            flush_d;
   logic [1:0]      pc_src_e;
   logic [XLEN-1:0] pc_target_e;
   logic [XLEN-1:0] jalr_target_e;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic [31:0]     instr_d;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_plus4_d;
   logic            valid_d;
   logic            pred_taken_d;
   logic [XLEN-1:0] pred_target_d;
   logic            btb_upd_valid;
   logic [XLEN-1:0] btb_upd_pc;
   logic [XLEN-1:0] btb_upd_target;
   logic            btb_upd_taken;

   modport master (
      output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, jalr_target_e,
             imem_rdata, btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
      input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, pred_taken_d, pred_target_d
   );

   modport slave (
      input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, jalr_target_e,
             imem_rdata, btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
      output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, pred_taken_d, pred_target_d
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, next-PC select and IF/ID register.
// Optional direct-mapped BTB is enabled by defining the macro BTB_EN.
module fetch_stage #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [31:0]     NOP_INSTR   = 32'h0000_0013
) (
   input logic          clk,
   input logic          rst,
   fetch_stage_if.slave bus
);
   logic [XLEN-1:0] r_pc_f;
   logic [XLEN-1:0] w_pc_plus4_f;
   logic [XLEN-1:0] w_pc_next;
   logic            w_btb_hit;
   logic [XLEN-1:0] w_btb_target;

   logic [31:0]     r_instr_d;
   logic [XLEN-1:0] r_pc_d;
   logic [XLEN-1:0] r_pc_plus4_d;
   logic            r_valid_d;
   logic            r_pred_taken_d;
   logic [XLEN-1:0] r_pred_target_d;

   assign w_pc_plus4_f = r_pc_f + XLEN'(4);

`ifdef BTB_EN
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] r_btb_valid;
   logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];

   logic [IDX_W-1:0] w_lkp_idx;
   logic [TAG_W-1:0] w_lkp_tag;
   logic [IDX_W-1:0] w_upd_idx;
   logic [TAG_W-1:0] w_upd_tag;
   logic             w_unused;

   assign w_lkp_idx = r_pc_f[IDX_W+1:2];
   assign w_lkp_tag = r_pc_f[XLEN-1:IDX_W+2];
   assign w_upd_idx = bus.btb_upd_pc[IDX_W+1:2];
   assign w_upd_tag = bus.btb_upd_pc[XLEN-1:IDX_W+2];
   assign w_unused  = &{1'b0, bus.btb_upd_pc[1:0], bus.jalr_target_e[0]};

   assign w_btb_hit    = r_btb_valid[w_lkp_idx] && (r_btb_tag[w_lkp_idx] == w_lkp_tag);
   assign w_btb_target = w_btb_hit ? r_btb_target[w_lkp_idx] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btb_valid <= '0;
      end else if (bus.btb_upd_valid) begin
         if (bus.btb_upd_taken) begin
            r_btb_valid[w_upd_idx] <= 1'b1;
         end else if (r_btb_tag[w_upd_idx] == w_upd_tag) begin
            r_btb_valid[w_upd_idx] <= 1'b0;
         end
      end
   end

   // NOTE: tag/target arrays have no reset; the valid bits alone gate every hit,
   // which keeps the arrays mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && bus.btb_upd_valid && bus.btb_upd_taken) begin
         r_btb_tag[w_upd_idx]    <= w_upd_tag;
         r_btb_target[w_upd_idx] <= bus.btb_upd_target;
      end
   end
`else
   logic w_unused;

   assign w_btb_hit    = 1'b0;
   assign w_btb_target = '0;
   assign w_unused     = &{1'b0, bus.jalr_target_e[0], bus.btb_upd_valid, bus.btb_upd_pc,
                           bus.btb_upd_target, bus.btb_upd_taken, (BTB_ENTRIES > 0)};
`endif

   // NOTE: default assigned first so every path through the block drives
   // w_pc_next and no latch is inferred.
   always_comb begin
      w_pc_next = w_pc_plus4_f;
      if (bus.pc_src_e == 2'b01) begin
         w_pc_next = bus.pc_target_e;
      end else if (bus.pc_src_e == 2'b10) begin
         w_pc_next = {bus.jalr_target_e[XLEN-1:1], 1'b0};
      end else if (bus.stall_f) begin
         w_pc_next = r_pc_f;
      end else if (w_btb_hit) begin
         w_pc_next = w_btb_target;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc_f <= RESET_PC;
      end else begin
         r_pc_f <= w_pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush_d) begin
         r_instr_d       <= NOP_INSTR;
         r_pc_d          <= '0;
         r_pc_plus4_d    <= '0;
         r_valid_d       <= 1'b0;
         r_pred_taken_d  <= 1'b0;
         r_pred_target_d <= '0;
      end else if (!bus.stall_d) begin
         r_instr_d       <= bus.imem_rdata;
         r_pc_d          <= r_pc_f;
         r_pc_plus4_d    <= w_pc_plus4_f;
         r_valid_d       <= 1'b1;
         r_pred_taken_d  <= w_btb_hit;
         r_pred_target_d <= w_btb_target;
      end
   end

   assign bus.imem_addr     = r_pc_f;
   assign bus.instr_d       = r_instr_d;
   assign bus.pc_d          = r_pc_d;
   assign bus.pc_plus4_d    = r_pc_plus4_d;
   assign bus.valid_d       = r_valid_d;
   assign bus.pred_taken_d  = r_pred_taken_d;
   assign bus.pred_target_d = r_pred_target_d;
endmodule
